// File: rtl/dsc_pkg.sv
// Shared definitions for the stochastic-multiplier sequencer: default widths,
// watchdog limit and the controller state encoding.
package dsc_pkg;

  localparam int SNG_WIDTH_DEF      = 4;
  localparam int TIMEOUT_CYCLES_DEF = 80;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_RUN    = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } dsc_state_t;

endpackage

// File: rtl/dsc_edge_det.sv
// Rising-edge detector for the multiplier stream-complete level.
// While clear is high no edge is reported and the history tracks the input.
module dsc_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic d,
  output logic rise
);

  logic r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= d;
    end
  end

  // History is taken during clear, so a level already high entering RUN never counts.
  assign rise = d & ~r_prev & ~clear;

endmodule

// File: rtl/dsc_mul_seq.sv
// Sequencer that loads an operand pair into an external stochastic multiplier,
// waits for its stream-complete edge (or a watchdog timeout) and returns the result.
//
// state  | meaning
// IDLE   | ready for an operand pair
// CLEAR  | multiplier/accumulator cleared, watchdog reset
// RUN    | multiplier enabled, waiting for mul_ov rising edge
// SETTLE | one quiet cycle before sampling mul_z
// DONE   | result held until out_ready
module dsc_mul_seq
  import dsc_pkg::*;
#(
  parameter int SNG_WIDTH      = SNG_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SNG_WIDTH-1:0]   in_a,
  input  logic [SNG_WIDTH-1:0]   in_b,
  output logic [SNG_WIDTH-1:0]   mul_a,
  output logic [SNG_WIDTH-1:0]   mul_b,
  output logic                   mul_en,
  output logic                   mul_rst,
  input  logic [2*SNG_WIDTH-1:0] mul_z,
  input  logic                   mul_ov,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*SNG_WIDTH-1:0] out_z,
  output logic                   out_err
);

  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  dsc_state_t             r_state;
  logic [WD_W-1:0]        r_wd;
  logic                   r_mul_en;
  logic                   r_out_valid;
  logic                   r_out_err;
  logic [2*SNG_WIDTH-1:0] r_out_z;
  logic [SNG_WIDTH-1:0]   r_mul_a;
  logic [SNG_WIDTH-1:0]   r_mul_b;
  logic                   w_clear;
  logic                   w_rise;

  assign w_clear = (r_state == ST_CLEAR);

  dsc_edge_det u_ov_edge (
    .clk   (clk),
    .rst   (rst),
    .clear (w_clear),
    .d     (mul_ov),
    .rise  (w_rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_wd        <= '0;
      r_mul_en    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_err   <= 1'b0;
      r_out_z     <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_mul_a <= in_a;
            r_mul_b <= in_b;
            r_state <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          r_wd     <= '0;
          r_mul_en <= 1'b1;
          r_state  <= ST_RUN;
        end
        ST_RUN: begin
          // An edge wins over a coincident watchdog expiry.
          if (w_rise) begin
            r_mul_en <= 1'b0;
            r_state  <= ST_SETTLE;
          end else if (r_wd == WD_LAST) begin
            r_mul_en    <= 1'b0;
            r_out_z     <= '0;
            r_out_err   <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        ST_SETTLE: begin
          r_out_z     <= mul_z;
          r_out_err   <= 1'b0;
          r_out_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_mul_en    <= 1'b0;
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Enable drops in the edge cycle itself so the accumulator stops on completion.
  assign mul_en    = r_mul_en & ~w_rise;
  assign mul_rst   = rst | w_clear;
  assign in_ready  = (r_state == ST_IDLE) & ~rst;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign out_valid = r_out_valid;
  assign out_z     = r_out_z;
  assign out_err   = r_out_err;

endmodule

// File: tb/tb_dsc_mul_seq.sv
// Directed bench for dsc_mul_seq with a behavioural stub multiplier that raises
// mul_ov a programmable number of enabled cycles after its clear.
module tb_dsc_mul_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic [3:0] mul_a;
  logic [3:0] mul_b;
  logic       mul_en;
  logic       mul_rst;
  logic [7:0] mul_z;
  logic       mul_ov;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_z;
  logic       out_err;

  logic       stub_on  = 1'b0;
  logic       force_hi = 1'b0;
  logic [7:0] stub_lat = 8'd0;
  logic [7:0] stub_z   = 8'h00;
  logic [7:0] stub_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dsc_mul_seq #(.SNG_WIDTH(4), .TIMEOUT_CYCLES(80)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_a(mul_a), .mul_b(mul_b),
    .mul_en(mul_en), .mul_rst(mul_rst), .mul_z(mul_z), .mul_ov(mul_ov),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_err(out_err)
  );

  always @(posedge clk) begin
    if (mul_rst) stub_cnt <= 8'd0;
    else if (mul_en && stub_cnt != 8'hFF) stub_cnt <= stub_cnt + 8'd1;
  end

  assign mul_ov = force_hi | (stub_on && (stub_cnt >= stub_lat) && !mul_rst);
  assign mul_z  = stub_z;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_accept(input logic [3:0] a, input logic [3:0] b);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks += 8;
    if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    if (mul_en !== 1'b0)    begin n_fail++; $display("FAIL rst_mul_en got %b want 0", mul_en); end
    if (mul_rst !== 1'b1)   begin n_fail++; $display("FAIL rst_mul_rst got %b want 1", mul_rst); end
    if (mul_a !== 4'h0)     begin n_fail++; $display("FAIL rst_mul_a got %h want 0", mul_a); end
    if (mul_b !== 4'h0)     begin n_fail++; $display("FAIL rst_mul_b got %h want 0", mul_b); end
    if (out_z !== 8'h00)    begin n_fail++; $display("FAIL rst_out_z got %h want 00", out_z); end
    if (out_err !== 1'b0)   begin n_fail++; $display("FAIL rst_out_err got %b want 0", out_err); end
    rst = 1'b0;
    #1;
    n_checks += 2;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready got %b want 1", in_ready); end
    if (mul_rst !== 1'b0)  begin n_fail++; $display("FAIL post_rst_mul_rst got %b want 0", mul_rst); end
  endtask

  task automatic test_min_latency();
    stub_on = 1'b1; stub_lat = 8'd0; stub_z = 8'h11;
    do_accept(4'd3, 4'd5);
    n_checks += 5;
    if (mul_rst !== 1'b1)  begin n_fail++; $display("FAIL clr_mul_rst got %b want 1", mul_rst); end
    if (mul_en !== 1'b0)   begin n_fail++; $display("FAIL clr_mul_en got %b want 0", mul_en); end
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL clr_in_ready got %b want 0", in_ready); end
    if (mul_a !== 4'd3)    begin n_fail++; $display("FAIL clr_mul_a got %h want 3", mul_a); end
    if (mul_b !== 4'd5)    begin n_fail++; $display("FAIL clr_mul_b got %h want 5", mul_b); end
    tick();
    n_checks += 1;
    if (mul_en !== 1'b0) begin n_fail++; $display("FAIL edge_cycle_mul_en got %b want 0", mul_en); end
    tick();
    n_checks += 2;
    if (mul_en !== 1'b0)    begin n_fail++; $display("FAIL settle_mul_en got %b want 0", mul_en); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL settle_out_valid got %b want 0", out_valid); end
    tick();
    n_checks += 3;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL min_lat_out_valid got %b want 1", out_valid); end
    if (out_z !== 8'h11)    begin n_fail++; $display("FAIL min_lat_out_z got %h want 11", out_z); end
    if (out_err !== 1'b0)   begin n_fail++; $display("FAIL min_lat_out_err got %b want 0", out_err); end
    handshake();
    n_checks += 2;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hs_out_valid got %b want 0", out_valid); end
    if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL hs_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_nominal();
    int n;
    stub_on = 1'b1; stub_lat = 8'd64; stub_z = 8'h24;
    do_accept(4'd6, 4'd6);
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
      if (n == 1) begin
        n_checks += 2;
        if (mul_en !== 1'b1)  begin n_fail++; $display("FAIL run_mul_en got %b want 1", mul_en); end
        if (mul_rst !== 1'b0) begin n_fail++; $display("FAIL run_mul_rst got %b want 0", mul_rst); end
      end
    end
    n_checks += 5;
    if (n != 67)          begin n_fail++; $display("FAIL nominal_latency got %0d want 67", n); end
    if (out_z !== 8'h24)  begin n_fail++; $display("FAIL nominal_out_z got %h want 24", out_z); end
    if (out_err !== 1'b0) begin n_fail++; $display("FAIL nominal_out_err got %b want 0", out_err); end
    if (mul_a !== 4'd6)   begin n_fail++; $display("FAIL nominal_mul_a got %h want 6", mul_a); end
    if (mul_b !== 4'd6)   begin n_fail++; $display("FAIL nominal_mul_b got %h want 6", mul_b); end
    handshake();
  endtask

  task automatic test_timeout();
    int n;
    stub_on = 1'b0;
    do_accept(4'd9, 4'd2);
    wait_valid(n);
    n_checks += 3;
    if (n != 81)          begin n_fail++; $display("FAIL timeout_latency got %0d want 81", n); end
    if (out_z !== 8'h00)  begin n_fail++; $display("FAIL timeout_out_z got %h want 00", out_z); end
    if (out_err !== 1'b1) begin n_fail++; $display("FAIL timeout_out_err got %b want 1", out_err); end
    handshake();
  endtask

  task automatic test_coincident();
    int n;
    stub_on = 1'b1; stub_lat = 8'd79; stub_z = 8'h5A;
    do_accept(4'd7, 4'd1);
    wait_valid(n);
    n_checks += 3;
    if (n != 82)          begin n_fail++; $display("FAIL coinc_latency got %0d want 82", n); end
    if (out_z !== 8'h5A)  begin n_fail++; $display("FAIL coinc_out_z got %h want 5a", out_z); end
    if (out_err !== 1'b0) begin n_fail++; $display("FAIL coinc_out_err got %b want 0", out_err); end
    handshake();
  endtask

  task automatic test_held_ov();
    int n;
    int seen;
    stub_on = 1'b0; stub_z = 8'h33; force_hi = 1'b1;
    tick();
    do_accept(4'd1, 4'd1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) seen++;
    end
    n_checks += 2;
    if (seen != 0)       begin n_fail++; $display("FAIL held_ov_early got %0d want 0", seen); end
    if (mul_en !== 1'b1) begin n_fail++; $display("FAIL held_ov_mul_en got %b want 1", mul_en); end
    force_hi = 1'b0;
    tick();
    tick();
    force_hi = 1'b1;
    wait_valid(n);
    n_checks += 3;
    if (n != 2)           begin n_fail++; $display("FAIL held_ov_latency got %0d want 2", n); end
    if (out_z !== 8'h33)  begin n_fail++; $display("FAIL held_ov_out_z got %h want 33", out_z); end
    if (out_err !== 1'b0) begin n_fail++; $display("FAIL held_ov_out_err got %b want 0", out_err); end
    force_hi = 1'b0;
    handshake();
  endtask

  task automatic test_stall();
    int n;
    stub_on = 1'b1; stub_lat = 8'd3; stub_z = 8'h47;
    do_accept(4'd4, 4'd5);
    wait_valid(n);
    n_checks += 1;
    if (n != 6) begin n_fail++; $display("FAIL stall_latency got %0d want 6", n); end
    stub_z = 8'h99;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_a = 4'hF; in_b = 4'hF;
      tick();
      n_checks += 4;
      if (out_z !== 8'h47)    begin n_fail++; $display("FAIL stall_out_z[%0d] got %h want 47", i, out_z); end
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid[%0d] got %b want 1", i, out_valid); end
      if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL stall_in_ready[%0d] got %b want 0", i, in_ready); end
      if (mul_a !== 4'd4)     begin n_fail++; $display("FAIL stall_mul_a[%0d] got %h want 4", i, mul_a); end
    end
    in_valid = 1'b0;
    handshake();
    n_checks += 3;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_hs_out_valid got %b want 0", out_valid); end
    if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL stall_hs_in_ready got %b want 1", in_ready); end
    if (mul_b !== 4'd5)     begin n_fail++; $display("FAIL stall_hs_mul_b got %h want 5", mul_b); end
  endtask

  task automatic test_rst_mid_run();
    int n;
    stub_on = 1'b0;
    do_accept(4'd7, 4'd3);
    tick();
    for (int i = 0; i < 30; i++) tick();
    rst = 1'b1;
    #1;
    n_checks += 2;
    if (mul_rst !== 1'b1)  begin n_fail++; $display("FAIL midrun_mul_rst got %b want 1", mul_rst); end
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midrun_in_ready got %b want 0", in_ready); end
    tick();
    rst = 1'b0;
    #1;
    n_checks += 4;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrun_out_valid got %b want 0", out_valid); end
    if (mul_en !== 1'b0)    begin n_fail++; $display("FAIL midrun_mul_en got %b want 0", mul_en); end
    if (mul_a !== 4'd0)     begin n_fail++; $display("FAIL midrun_mul_a got %h want 0", mul_a); end
    if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL midrun_idle got %b want 1", in_ready); end
    stub_on = 1'b1; stub_lat = 8'd2; stub_z = 8'h2B;
    do_accept(4'd2, 4'd2);
    wait_valid(n);
    n_checks += 3;
    if (n != 5)           begin n_fail++; $display("FAIL after_rst_latency got %0d want 5", n); end
    if (out_z !== 8'h2B)  begin n_fail++; $display("FAIL after_rst_out_z got %h want 2b", out_z); end
    if (out_err !== 1'b0) begin n_fail++; $display("FAIL after_rst_out_err got %b want 0", out_err); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks += 2;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL done_rst_out_valid got %b want 0", out_valid); end
    if (out_z !== 8'h00)    begin n_fail++; $display("FAIL done_rst_out_z got %h want 00", out_z); end
  endtask

  initial begin
    test_reset();
    test_min_latency();
    test_nominal();
    test_timeout();
    test_coincident();
    test_held_ov();
    test_stall();
    test_rst_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
